pif_led_sequencer: RTL and testbench

//   Multi-channel LED sequencer, the parametrised successor of the two-colour flasher.

---
 rtl/pif_led_sequencer.sv | 94 +++++++++
 tb/tb_pif_led_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pif_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pif_led_sequencer
// Purpose  : Multi-channel LED sequencer (OFF/ON/BLINK/BREATHE) on a shared tick.
// Revision : 1.0  initial release
// ============================================================================
module pif_led_sequencer #(
   parameter int CHANNELS   = 3,
   parameter int B          = 5,
   parameter int TICK_DIV   = 177333,
   parameter int ACTIVE_LOW = 1,
   localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                WrEn,
   input  logic [CW-1:0]       WrChan,
   input  logic [1:0]          WrMode,
   input  logic [B:0]          WrPhase,
   output logic [CHANNELS-1:0] Led,
   output logic                Tick
);

   localparam int                c_PW           = $clog2(TICK_DIV);
   localparam logic [c_PW-1:0]   c_RELOAD       = c_PW'(TICK_DIV - 1);
   localparam logic              c_DARK         = (ACTIVE_LOW != 0);
   localparam logic [1:0]        c_MODE_OFF     = 2'd0;
   localparam logic [1:0]        c_MODE_ON      = 2'd1;
   localparam logic [1:0]        c_MODE_BLINK   = 2'd2;
   localparam logic [1:0]        c_MODE_BREATHE = 2'd3;

   logic [c_PW-1:0]     r_cnt;
   logic                r_tick;
   logic [CHANNELS-1:0] w_on;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_cnt  <= c_RELOAD;
         r_tick <= 1'b0;
      end else if (r_cnt == '0) begin
         r_cnt  <= c_RELOAD;
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt - c_PW'(1);
         r_tick <= 1'b0;
      end
   end

   assign Tick = r_tick;

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
      logic [1:0]   r_mode;
      logic [B:0]   r_lvl;
      logic [B:0]   r_acc;
      logic [B-1:0] w_duty;
      logic         w_sel;

      assign w_sel  = WrEn && (WrChan == CW'(ch));
      // Folding the upper half of the ramp gives a 0..max..0 triangle.
      assign w_duty = r_lvl[B] ? ~r_lvl[B-1:0] : r_lvl[B-1:0];

      // A write on this channel takes priority over a coincident tick.
      always_ff @(posedge Clk or posedge Rst) begin
         if (Rst) begin
            r_mode <= c_MODE_OFF;
            r_lvl  <= '0;
            r_acc  <= '0;
         end else if (w_sel) begin
            r_mode <= WrMode;
            r_lvl  <= WrPhase;
            r_acc  <= '0;
         end else if (r_tick) begin
            r_lvl  <= r_lvl + (B+1)'(1);
            r_acc  <= '0;
         end else begin
            r_acc  <= {1'b0, r_acc[B-1:0]} + {1'b0, w_duty};
         end
      end

      assign w_on[ch] = ((r_mode == c_MODE_ON))
                      | ((r_mode == c_MODE_BLINK)   & ~r_lvl[B])
                      | ((r_mode == c_MODE_BREATHE) &  r_acc[B]);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Led <= {CHANNELS{c_DARK}};
      end else begin
         Led <= w_on ^ {CHANNELS{c_DARK}};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pif_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pif_led_sequencer
// Purpose  : Self-checking bench for pif_led_sequencer (both LED polarities).
// Revision : 1.0  initial release
// ============================================================================
module tb_pif_led_sequencer;

   localparam int CH = 3;
   localparam int BB = 3;
   localparam int TD = 8;
   localparam int M  = 8;     // 2^BB
   localparam int NL = 16;    // 2^(BB+1) ramp length

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       WrEn = 1'b0;
   logic [1:0] WrChan = 2'd0;
   logic [1:0] WrMode = 2'd0;
   logic [3:0] WrPhase = 4'd0;
   logic [2:0] led_al;
   logic [2:0] led_ah;
   logic       tick_al;
   logic       tick_ah;

   always #5 Clk = ~Clk;

   pif_led_sequencer #(.CHANNELS(CH), .B(BB), .TICK_DIV(TD), .ACTIVE_LOW(1)) dut (
      .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrChan(WrChan), .WrMode(WrMode),
      .WrPhase(WrPhase), .Led(led_al), .Tick(tick_al));

   pif_led_sequencer #(.CHANNELS(CH), .B(BB), .TICK_DIV(TD), .ACTIVE_LOW(0)) dut_ah (
      .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrChan(WrChan), .WrMode(WrMode),
      .WrPhase(WrPhase), .Led(led_ah), .Tick(tick_ah));

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: edges since reset release, per-channel mode, ramp level
   // and number of PWM additions since the accumulator was last cleared.
   int         cyc;
   int         m_mode[CH];
   int         m_lvl[CH];
   int         m_j[CH];
   logic [2:0] m_lit = 3'b000;
   logic       m_tick = 1'b0;
   bit         m_tk;

   function automatic bit breathe_on(input int lvl, input int j);
      int d;
      d = (lvl >= M) ? (NL - 1 - lvl) : lvl;
      return (j >= 1) && (((j * d) / M) != (((j - 1) * d) / M));
   endfunction

   function automatic bit on_req(input int mode, input int lvl, input int j);
      case (mode)
         1:       return 1'b1;
         2:       return lvl < M;
         3:       return breathe_on(lvl, j);
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge Clk) begin
      if (Rst) begin
         cyc    = 0;
         m_lit  = 3'b000;
         m_tick = 1'b0;
         for (int i = 0; i < CH; i++) begin
            m_mode[i] = 0; m_lvl[i] = 0; m_j[i] = 0;
         end
      end else begin
         m_tk = m_tick;
         for (int i = 0; i < CH; i++) m_lit[i] = on_req(m_mode[i], m_lvl[i], m_j[i]);
         for (int i = 0; i < CH; i++) begin
            if (WrEn && (int'(WrChan) == i)) begin
               m_mode[i] = int'(WrMode);
               m_lvl[i]  = int'(WrPhase);
               m_j[i]    = 0;
            end else if (m_tk) begin
               m_lvl[i]  = (m_lvl[i] + 1) % NL;
               m_j[i]    = 0;
            end else begin
               m_j[i]    = m_j[i] + 1;
            end
         end
         cyc    = cyc + 1;
         m_tick = (cyc % TD) == 0;
      end
   end

   logic [2:0] e_al;
   logic [2:0] e_ah;
   logic       e_tk;

   always @(negedge Clk) begin
      if (chk_en) begin
         e_al = Rst ? 3'b111 : ~m_lit;
         e_ah = Rst ? 3'b000 :  m_lit;
         e_tk = Rst ? 1'b0   :  m_tick;
         chk("led_al", 32'(led_al), 32'(e_al));
         chk("led_ah", 32'(led_ah), 32'(e_ah));
         chk("tick_al", 32'(tick_al), 32'(e_tk));
         chk("tick_ah", 32'(tick_ah), 32'(e_tk));
      end
   end

   task automatic wr(input int ch, input int mode, input int phase);
      WrChan  = 2'(ch);
      WrMode  = 2'(mode);
      WrPhase = 4'(phase);
      WrEn    = 1'b1;
      @(posedge Clk);
      #1 WrEn = 1'b0;
   endtask

   task automatic wait_tick(output int k);
      k = 0;
      @(negedge Clk);
      while (tick_al !== 1'b1 && k < 20) begin
         @(negedge Clk);
         k++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int cnt;
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b0;
      chk_en = 1'b1;

      // Reset state and prescaler timing
      @(negedge Clk);
      chk("reset_led_al", 32'(led_al), 32'h7);
      chk("reset_led_ah", 32'(led_ah), 32'h0);
      k = 0;
      while (tick_al !== 1'b1 && k < 40) begin
         @(negedge Clk);
         k++;
      end
      chk("first_tick_cycles", k, 8);
      @(negedge Clk);
      chk("tick_width", 32'(tick_al), 32'h0);
      k = 1;
      while (tick_al !== 1'b1 && k < 40) begin
         @(negedge Clk);
         k++;
      end
      chk("tick_period", k, 8);

      // ON write latency: visible two edges after the sampling edge
      #1 wr(1, 1, 0);
      @(negedge Clk);
      chk("on_lat_n1", 32'(led_al[1]), 32'h1);
      @(negedge Clk);
      chk("on_lat_n2", 32'(led_al[1]), 32'h0);
      chk("on_others", 32'({led_al[2], led_al[0]}), 32'h3);

      // Out-of-range channel is ignored
      #1 wr(3, 1, 0);
      repeat (3) @(negedge Clk);
      chk("bad_chan_led", 32'(led_al), 32'h5);

      // BLINK written coincident with Tick: phase must load unincremented
      wait_tick(k);
      chk("tick_found_blink", 32'(k < 20), 32'h1);
      #1 wr(0, 2, 0);
      k = 0;
      while (led_al[0] !== 1'b0 && k < 10) begin
         @(negedge Clk);
         k++;
      end
      cnt = 0;
      while (led_al[0] === 1'b0 && cnt < 200) begin
         cnt++;
         @(negedge Clk);
      end
      chk("blink_low_run", cnt, 64);
      cnt = 0;
      while (led_al[0] === 1'b1 && cnt < 200) begin
         cnt++;
         @(negedge Clk);
      end
      chk("blink_high_run", cnt, 64);

      // BREATHE phase 3: windows at Lvl 4 and 5
      #1 wr(2, 3, 3);
      wait_tick(k);
      chk("tick_found_breathe", 32'(k < 20), 32'h1);
      @(negedge Clk);
      cnt = 0;
      repeat (8) begin
         @(negedge Clk);
         if (led_al[2] === 1'b0) cnt++;
      end
      chk("breathe_win_lvl4", cnt, 3);
      cnt = 0;
      repeat (8) begin
         @(negedge Clk);
         if (led_al[2] === 1'b0) cnt++;
      end
      chk("breathe_win_lvl5", cnt, 4);

      // Randomized writes against the model
      repeat (3000) begin
         @(posedge Clk);
         #1;
         if ($urandom_range(0, 15) == 0) begin
            WrChan  = 2'($urandom_range(0, 3));
            WrMode  = 2'($urandom_range(0, 3));
            WrPhase = 4'($urandom_range(0, 15));
            WrEn    = 1'b1;
         end else begin
            WrEn    = 1'b0;
         end
      end
      @(posedge Clk);
      #1 WrEn = 1'b0;

      // Asynchronous reset mid-BREATHE
      wr(1, 1, 0);
      wr(2, 3, 5);
      repeat (20) @(posedge Clk);
      #1;
      chk("pre_rst_on", 32'(led_al[1]), 32'h0);
      #1 Rst = 1'b1;
      #1;
      chk("async_rst_al", 32'(led_al), 32'h7);
      chk("async_rst_ah", 32'(led_ah), 32'h0);
      chk("async_rst_tick", 32'(tick_al), 32'h0);
      @(posedge Clk);
      #1 Rst = 1'b0;
      repeat (40) @(negedge Clk);
      chk("post_rst_al", 32'(led_al), 32'h7);
      chk("post_rst_ah", 32'(led_ah), 32'h0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
